// File: rtl/block_plot_arbiter.sv
// Round-robin arbiter that shares the vga_adapter pixel port between erase, head and
// apple requesters, rastering one XDIM x YDIM block per grant, one pixel per clock.
`timescale 1ns/1ps
module block_plot_arbiter #(
  parameter int XDIM    = 10,
  parameter int YDIM    = 10,
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [2:0]  VGA_COLOR,
  output logic        plot
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [3:0] XC_LAST = 4'(XDIM - 1);
  localparam logic [3:0] YC_LAST = 4'(YDIM - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  xc;
  logic [3:0]  yc;
  logic [1:0]  last;
  logic [2:0]  owner;
  logic [7:0]  bx;
  logic [6:0]  by;
  logic [2:0]  bc;

  logic        any_req;
  logic [1:0]  win;
  logic [2:0]  win_oh;
  logic        fill_end;
  logic        in_fill;
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;

  // First set request bit searching last+1, last+2, last (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = l;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(l) + k) % 3);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign any_req  = |req;
  assign win      = rr_pick(req, last);
  assign win_oh   = 3'b001 << win;
  assign fill_end = (xc == XC_LAST) && (yc == YC_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_FILL;
      S_FILL:  if (fill_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
      xc    <= '0;
      yc    <= '0;
      last  <= 2'd2;
      owner <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          xc <= '0;
          yc <= '0;
          if (any_req) begin
            owner <= win_oh;
            last  <= win;
          end else begin
            owner <= '0;
          end
        end
        S_FILL: begin
          if (xc == XC_LAST) begin
            xc <= '0;
            yc <= yc + 4'd1;
          end else begin
            xc <= xc + 4'd1;
          end
        end
        S_DONE:  owner <= '0;
        default: owner <= '0;
      endcase
    end
  end

  // Block origin and colour are data: latched at grant, never reset.
  always_ff @(posedge Clock) begin
    if (state == S_IDLE && any_req) begin
      bx <= req_x[8*int'(win) +: 8];
      by <= req_y[7*int'(win) +: 7];
      bc <= req_colour[3*int'(win) +: 3];
    end
  end

  // Outputs decode registered state only; req never reaches them combinationally.
  assign in_fill = (state == S_FILL);
  assign sum_x   = {1'b0, bx} + {5'd0, xc};
  assign sum_y   = {1'b0, by} + {4'd0, yc};

  assign grant     = owner;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) ? owner : 3'b000;
  assign VGA_X     = in_fill ? sum_x[7:0] : 8'd0;
  assign VGA_Y     = in_fill ? sum_y[6:0] : 7'd0;
  assign VGA_COLOR = in_fill ? bc : 3'd0;
  assign plot      = in_fill && (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));

endmodule

// File: tb/tb_block_plot_arbiter.sv
// Bench for block_plot_arbiter: directed scenarios plus random blocks checked against
// a reference built from the arbitration and raster rules.
`timescale 1ns/1ps
module tb_block_plot_arbiter;

  localparam int XDIM = 10;
  localparam int YDIM = 10;
  localparam int XS   = 160;
  localparam int YS   = 120;
  localparam int NPIX = XDIM * YDIM;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [2:0]  VGA_COLOR;
  logic        plot;

  int n_cmp = 0;
  int n_bad = 0;
  int last_m = 2;

  block_plot_arbiter #(.XDIM(XDIM), .YDIM(YDIM), .XSCREEN(XS), .YSCREEN(YS)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .done(done), .busy(busy),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requesting index after the previous winner, wrapping mod 3.
  function automatic int rr_winner(input logic [2:0] r, input int prev);
    for (int k = 1; k <= 3; k++)
      if (r[(prev + k) % 3]) return (prev + k) % 3;
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_plot"}, 32'(plot), 0);
    chk({tag, "_colour"}, 32'(VGA_COLOR), 0);
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
  task automatic do_block(input string tag, input logic [2:0] r, input logic [23:0] px,
                          input logic [20:0] py, input logic [8:0] pc, input logic [2:0] after,
                          input int withdraw_at, output int plots);
    int w, bx, by, bc, ex, ey;
    logic vis;
    req = r; req_x = px; req_y = py; req_colour = pc;
    w = rr_winner(r, last_m);
    last_m = w;
    bx = int'(px[8*w +: 8]);
    by = int'(py[7*w +: 7]);
    bc = int'(pc[3*w +: 3]);
    plots = 0;
    for (int p = 0; p < NPIX; p++) begin
      @(negedge Clock);
      ex = bx + p % XDIM;
      ey = by + p / XDIM;
      vis = (ex < XS) && (ey < YS);
      chk({tag, "_grant"}, 32'(grant), 32'(1 << w));
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_done_early"}, 32'(done), 0);
      chk({tag, "_plot"}, 32'(plot), 32'(vis));
      chk({tag, "_x"}, 32'(VGA_X), 32'(ex % 256));
      chk({tag, "_y"}, 32'(VGA_Y), 32'(ey % 128));
      chk({tag, "_colour"}, 32'(VGA_COLOR), 32'(bc));
      if (plot === 1'b1) plots++;
      req_x = 24'($urandom);
      req_y = 21'($urandom);
      req_colour = 9'($urandom);
      if (p == withdraw_at) req = '0;
    end
    @(negedge Clock);
    chk({tag, "_done"}, 32'(done), 32'(1 << w));
    chk({tag, "_done_grant"}, 32'(grant), 32'(1 << w));
    chk({tag, "_done_busy"}, 32'(busy), 1);
    chk({tag, "_done_plot"}, 32'(plot), 0);
    req = after;
    @(negedge Clock);
    check_idle({tag, "_gap"});
  endtask

  initial begin
    int plots;
    int w;
    logic [2:0] r;
    logic [2:0] after;

    // Reset state
    repeat (2) @(negedge Clock);
    check_idle("rst");
    chk("rst_x", 32'(VGA_X), 0);
    chk("rst_y", 32'(VGA_Y), 0);
    Resetn = 1'b1;
    @(negedge Clock);
    check_idle("rst_rel");

    // T2: all three held, order 0,1,2,0 from reset
    for (int b = 0; b < 4; b++) begin
      do_block("t2", 3'b111, 24'($urandom), 21'($urandom), 9'($urandom),
               (b == 3) ? 3'b000 : 3'b111, -1, plots);
      chk("t2_order", 32'(last_m), 32'(b % 3));
    end

    // T1: single erase block fully on screen
    do_block("t1", 3'b001, 24'd39, 21'd59, 9'b000_000_010, 3'b000, -1, plots);
    chk("t1_plots", 32'(plots), 100);

    // T3: apple block clipped at the bottom-right corner
    do_block("t3", 3'b100, {8'd155, 16'd0}, {7'd115, 14'd0}, 9'b101_000_000, 3'b000, -1, plots);
    chk("t3_plots", 32'(plots), 25);

    // T5: head request rises during erase's DONE cycle
    do_block("t5a", 3'b001, 24'($urandom), 21'($urandom), 9'($urandom), 3'b010, -1, plots);
    do_block("t5b", 3'b010, 24'($urandom), 21'($urandom), 9'($urandom), 3'b000, -1, plots);
    chk("t5_winner", 32'(last_m), 1);

    // T6: erase withdraws after 10 pixels; block still completes
    do_block("t6", 3'b001, 24'($urandom), 21'($urandom), 9'($urandom), 3'b000, 9, plots);
    repeat (3) begin
      @(negedge Clock);
      check_idle("t6_after");
    end

    // Random requests, hold or drop after done
    for (int b = 0; b < 10; b++) begin
      r = 3'($urandom_range(1, 7));
      after = ($urandom_range(0, 1) == 1) ? r : 3'b000;
      do_block("rnd", r, 24'($urandom), 21'($urandom), 9'($urandom), after, -1, plots);
      if (after == 3'b000 && b < 9) begin
        @(negedge Clock);
        check_idle("rnd_idle");
      end
      if (b == 9 && after != 3'b000) begin
        req = '0;
        @(negedge Clock);
        w = rr_winner(after, last_m);
        last_m = w;
        repeat (NPIX + 1) @(negedge Clock);
        @(negedge Clock);
        check_idle("rnd_tail");
      end
    end

    // T4: reset at pixel 37 of an erase block
    req = 3'b001;
    req_x = {16'd0, 8'($urandom_range(0, 140))};
    req_y = {14'd0, 7'($urandom_range(0, 100))};
    req_colour = 9'($urandom);
    repeat (37) @(negedge Clock);
    chk("t4_pre_plot", 32'(plot), 1);
    chk("t4_pre_grant", 32'(grant), 1);
    Resetn = 1'b0;
    #1;
    chk("t4_plot", 32'(plot), 0);
    chk("t4_grant", 32'(grant), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_x", 32'(VGA_X), 0);
    last_m = 2;
    req = 3'b010;
    @(negedge Clock);
    check_idle("t4_held");
    Resetn = 1'b1;
    do_block("t4b", 3'b010, 24'($urandom), 21'($urandom), 9'($urandom), 3'b000, -1, plots);
    chk("t4_winner", 32'(last_m), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
